// File: rtl/rr_index_arbiter_16.sv
// rr_index_arbiter_16: 16-way round-robin arbiter with a registered grant index and valid flag.
// The optional hold-timeout release is enabled by defining ARB_TIMEOUT_EN.
module rr_index_arbiter_16 #(
   parameter int MAX_HOLD = 32,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        done,
   output logic [3:0]  grant_idx,
   output logic        grant_valid,
   output logic        busy
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
   state_t     state_q, state_d;
   logic [3:0] grant_idx_q, grant_idx_d;
   logic [3:0] ptr_q, ptr_d;
   logic [3:0] scan_off;
   logic [3:0] scan_idx;
   logic       any_req;
   logic       timeout;
   logic       release_evt;

   if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_cfg
      $error("rr_index_arbiter_16: MAX_HOLD must be 1..255 and below 2**CNT_W");
   end

   // Offset of the first requester at or after ptr, wrapping through index 15.
   always_comb begin
      scan_off = '0;
      for (int i = 15; i >= 0; i--)
         if (req[ptr_q + 4'(i)]) scan_off = 4'(i);
   end

   assign scan_idx = ptr_q + scan_off;
   assign any_req  = |req;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   // Held at zero while idle so it reads zero on the first GRANT cycle.
   always_comb hold_cnt_d = (state_q == IDLE) ? '0 : hold_cnt_q + CNT_W'(1);

   always_ff @(posedge clk)
      if (!rst_n) hold_cnt_q <= '0;
      else        hold_cnt_q <= hold_cnt_d;

   assign timeout = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`else
   assign timeout = 1'b0;
`endif

   assign release_evt = done | ~req[grant_idx_q] | timeout;

   always_ff @(posedge clk)
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         ptr_q       <= ptr_d;
      end

   always_comb begin
      state_d     = (state_q == IDLE) ? (any_req ? GRANT : IDLE) : (release_evt ? IDLE : GRANT);
      grant_idx_d = (state_q == IDLE && any_req) ? scan_idx : grant_idx_q;
      ptr_d       = (state_q == GRANT && release_evt) ? grant_idx_q + 4'd1 : ptr_q;
   end

   always_comb begin
      grant_idx   = grant_idx_q;
      grant_valid = (state_q == GRANT);
      busy        = (state_q == GRANT);
   end
endmodule

// File: tb/tb_rr_index_arbiter_16.sv
// tb_rr_index_arbiter_16: directed and random stimulus against a cycle-level reference model.
module tb_rr_index_arbiter_16;
   localparam int MAXH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        busy;

   int n_checks = 0;
   int n_fails  = 0;

   int m_valid = 0;
   int m_idx   = 0;
   int m_ptr   = 0;
   int m_cnt   = 0;

   rr_index_arbiter_16 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .grant_idx(grant_idx), .grant_valid(grant_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r_n, input logic [15:0] rq, input logic dn);
      bit rel;
      if (!r_n) begin
         m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_valid == 0) begin
         if (rq != 0) begin
            for (int k = 0; k < 16; k++)
               if (rq[(m_ptr + k) % 16]) begin
                  m_idx = (m_ptr + k) % 16;
                  break;
               end
            m_valid = 1;
            m_cnt = 0;
         end
      end else begin
         rel = dn || !rq[m_idx];
`ifdef ARB_TIMEOUT_EN
         if (m_cnt == MAXH - 1) rel = 1;
`endif
         if (rel) begin
            m_valid = 0;
            m_ptr = (m_idx + 1) % 16;
         end else m_cnt++;
      end
   endtask

   task automatic step(input logic r_n, input logic [15:0] rq, input logic dn);
      logic [15:0] dec, m_dec;
      @(negedge clk);
      rst_n = r_n; req = rq; done = dn;
      @(posedge clk);
      model_edge(r_n, rq, dn);
      #1;
      dec   = grant_valid ? (16'd1 << grant_idx) : 16'd0;
      m_dec = m_valid != 0 ? (16'd1 << m_idx) : 16'd0;
      check("grant_valid", 32'(grant_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_valid));
      check("grant_idx", 32'(grant_idx), 32'(m_idx));
      check("decoder_out", 32'(dec), 32'(m_dec));
   endtask

   initial begin
      int run, exp_run;
      step(0, 16'hFFFF, 0);
      step(0, 16'hFFFF, 0);
      check("reset_valid", 32'(grant_valid), 0);
      check("reset_idx", 32'(grant_idx), 0);
      // Single requester: granted, held 3 cycles, released by done, one-cycle gap.
      step(1, 16'h0020, 0);
      check("single_idx", 32'(grant_idx), 5);
      for (int i = 0; i < 3; i++) step(1, 16'h0020, 0);
      step(1, 16'h0020, 1);
      check("single_gap", 32'(grant_valid), 0);
      step(1, 16'h0020, 0);
      check("single_regrant", 32'(grant_idx), 5);
      step(1, 16'h0020, 1);
      step(1, 16'h0021, 0);
      check("ptr_after_5", 32'(grant_idx), 0);
      step(1, 16'h0021, 1);
      // Two requesters at the ends: wrap 15 -> 0 with done every grant.
      step(0, 16'h0000, 0);
      for (int i = 0; i < 8; i++) step(1, 16'h8001, 1);
      // Release by request drop, then simultaneous done and drop.
      step(0, 16'h0000, 0);
      step(1, 16'h0300, 0);
      check("drop_first", 32'(grant_idx), 8);
      step(1, 16'h0200, 0);
      step(1, 16'h0300, 0);
      check("drop_next", 32'(grant_idx), 9);
      step(1, 16'h0100, 1);
      step(1, 16'h0300, 0);
      check("single_advance", 32'(grant_idx), 8);
      step(1, 16'h0300, 1);
      // Reset in the middle of a grant.
      step(0, 16'h0000, 0);
      step(1, 16'h1000, 0);
      step(1, 16'h1000, 0);
      check("mid_grant_idx", 32'(grant_idx), 12);
      step(0, 16'h1000, 0);
      check("mid_reset_valid", 32'(grant_valid), 0);
      step(1, 16'h1001, 0);
      check("after_reset_idx", 32'(grant_idx), 0);
      // Hold with done never asserted.
      step(0, 16'h0000, 0);
      run = 0;
      for (int i = 0; i < 110; i++) begin
         step(1, 16'h0006, 0);
         if (grant_valid && grant_idx == 4'd1 && run == i) run++;
      end
`ifdef ARB_TIMEOUT_EN
      exp_run = MAXH;
`else
      exp_run = 110;
`endif
      check("hold_length", 32'(run), 32'(exp_run));
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] rq;
         rq = (i % 3 == 0) ? 16'($urandom) : (16'($urandom) & 16'($urandom) & 16'($urandom));
         step(($urandom_range(0, 63) != 0), rq, ($urandom_range(0, 3) == 0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
